pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the fixed per-stage latches (F/D, D/E, E/M, M/W) with one configurable block. The block carries an arbitrary payload plus PC, tracks a valid bit, and supports a valid/ready handshake so multi-cycle units (mult/div) can back-pressure upstream. It also provides flush-to-NOP for branch/exception squash, an optional skid slot for full throughput under back-pressure, and a saturating stall counter for performance debug.

---
 rtl/cpu_pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the five-stage MIPS pipeline: bubble encoding, reset PC
// and the payload widths each inter-stage register is instantiated with.
package cpu_pipe_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam int FD_W = 32;
  localparam int DE_W = 128;
  localparam int EM_W = 96;
  localparam int MW_W = 72;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit, payload and PC. An empty slot always holds the
// NOP payload and the reset PC so a bubble decodes as sll $0,$0,0.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [31:0]       load_pc,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [31:0]       pc
);

  localparam logic [DATA_W-1:0] EMPTY_DATA = DATA_W'(NOP_WORD);

  // clear wins over load so a squash can never be overridden by a refill.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      data  <= EMPTY_DATA;
      pc    <= RESET_PC;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register with valid/ready handshake,
// flush-to-NOP, optional skid slot and a saturating stall counter.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter bit          SKID     = 1'b1,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a presented entry is held
  // stable by its producer until it transfers.
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [31:0]       main_pc;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [31:0]       skid_pc;

  logic              accept;
  logic              consume;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_load_data;
  logic [31:0]       main_load_pc;

  assign accept  = in_valid && in_ready;
  assign consume = main_valid && out_ready;

  // A held skid entry has priority for refilling main; accept is impossible then.
  always_comb begin
    main_load      = 1'b0;
    main_load_data = in_data;
    main_load_pc   = in_pc;
    if (skid_valid) begin
      main_load      = consume;
      main_load_data = skid_data;
      main_load_pc   = skid_pc;
    end else begin
      main_load      = accept && (!main_valid || consume);
    end
    main_clear = flush || (consume && !main_load);
  end

  pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_load_data),
    .load_pc   (main_load_pc),
    .valid     (main_valid),
    .data      (main_data),
    .pc        (main_pc)
  );

  generate
    if (SKID) begin : g_skid
      logic skid_load;
      logic skid_clear;

      assign skid_load  = accept && main_valid && !consume;
      assign skid_clear = flush || (consume && skid_valid);
      // Registered ready: no combinational path from out_ready.
      assign in_ready   = !skid_valid;

      pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .load_pc   (in_pc),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = DATA_W'(NOP_WORD);
      assign skid_pc    = RESET_PC;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_pc    = main_pc;

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance and a SKID=0 instance,
// directed vectors, per-instance scoreboard monitors and a final report.
module tb_pipe_stage_reg;

  localparam int          DATA_W = 64;
  localparam logic [31:0] RPC    = 32'h0000_3000;
  localparam int          EW     = DATA_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic              s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [DATA_W-1:0] s_in_data, s_out_data;
  logic [31:0]       s_in_pc, s_out_pc;
  logic [3:0]        s_stall_cnt;

  // SKID=0 instance signals
  logic              n_reset, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [DATA_W-1:0] n_in_data, n_out_data;
  logic [31:0]       n_in_pc, n_out_pc;
  logic [15:0]       n_stall_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .SKID(1'b1), .RESET_PC(RPC), .CNT_W(4)) u_skid (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_pc(s_in_pc),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_pc(s_out_pc),
    .stall_cnt(s_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .SKID(1'b0), .RESET_PC(RPC), .CNT_W(16)) u_noskid (
    .clk(clk), .reset(n_reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_pc(n_in_pc),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_pc(n_out_pc),
    .stall_cnt(n_stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] s_exp_q[$];
  logic [EW-1:0] n_exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitors: pop on consume, push on accept, squash on flush/reset.
  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) check("s_unexpected_out", {s_out_pc, s_out_data}, '0);
      else check("s_out_entry", {s_out_pc, s_out_data}, s_exp_q.pop_front());
    end
    if (s_out_valid === 1'b0) check("s_bubble", {s_out_pc, s_out_data}, {RPC, {DATA_W{1'b0}}});
    if (s_reset || s_flush) s_exp_q.delete();
    else if (s_in_valid && s_in_ready) s_exp_q.push_back({s_in_pc, s_in_data});
  end

  always @(negedge clk) begin
    if (n_out_valid && n_out_ready) begin
      if (n_exp_q.size() == 0) check("n_unexpected_out", {n_out_pc, n_out_data}, '0);
      else check("n_out_entry", {n_out_pc, n_out_data}, n_exp_q.pop_front());
    end
    if (n_out_valid === 1'b0) check("n_bubble", {n_out_pc, n_out_data}, {RPC, {DATA_W{1'b0}}});
    if (n_reset || n_flush) n_exp_q.delete();
    else if (n_in_valid && n_in_ready) n_exp_q.push_back({n_in_pc, n_in_data});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [31:0] pc, input logic [DATA_W-1:0] d,
                         input logic rdy);
    s_in_valid  = v;
    s_in_pc     = pc;
    s_in_data   = d;
    s_out_ready = rdy;
  endtask

  task automatic n_drive(input logic v, input logic [31:0] pc, input logic [DATA_W-1:0] d,
                         input logic rdy);
    n_in_valid  = v;
    n_in_pc     = pc;
    n_in_data   = d;
    n_out_ready = rdy;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_reset = 1'b1; s_flush = 1'b0; s_drive(1'b0, 32'h0, '0, 1'b0);
    n_reset = 1'b1; n_flush = 1'b0; n_drive(1'b0, 32'h0, '0, 1'b0);
    tick(); tick();
    s_reset = 1'b0; n_reset = 1'b0;

    // Reset state
    check("s_rst_out_valid", s_out_valid, 1'b0);
    check("s_rst_in_ready",  s_in_ready,  1'b1);
    check("s_rst_stall",     s_stall_cnt, 4'h0);
    check("s_rst_pc",        s_out_pc,    RPC);
    check("n_rst_out_valid", n_out_valid, 1'b0);
    check("n_rst_stall",     n_stall_cnt, 16'h0);

    // Single entry, one-cycle latency, then idle bubble
    s_drive(1'b1, 32'h3000, 64'hA5, 1'b1);
    tick();
    s_drive(1'b0, 32'h0, '0, 1'b1);
    check("s_lat_valid", s_out_valid, 1'b1);
    check("s_lat_data",  s_out_data,  64'hA5);
    tick();
    check("s_idle_valid", s_out_valid, 1'b0);
    check("s_idle_data",  s_out_data,  64'h0);
    check("s_idle_pc",    s_out_pc,    32'h3000);

    // Back-to-back streaming on both instances
    for (int i = 0; i < 3; i++) begin
      s_drive(1'b1, 32'h3000 + 32'(4 * i), 64'(i + 1), 1'b1);
      n_drive(1'b1, 32'h3000 + 32'(4 * i), 64'(16 + i), 1'b1);
      tick();
      check("s_stream_valid", s_out_valid, 1'b1);
      check("s_stream_pc",    s_out_pc,    32'h3000 + 32'(4 * i));
      check("n_stream_valid", n_out_valid, 1'b1);
    end
    s_drive(1'b0, 32'h0, '0, 1'b1);
    n_drive(1'b0, 32'h0, '0, 1'b1);
    tick();
    check("s_stream_end", s_out_valid, 1'b0);
    check("n_stream_end", n_out_valid, 1'b0);

    // Skid absorbs one entry when out_ready falls
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    s_drive(1'b1, 32'h3000, 64'h100, 1'b0);
    tick();
    s_drive(1'b1, 32'h3004, 64'h104, 1'b0);
    check("s_skid_ready_pre", s_in_ready, 1'b1);
    tick();
    check("s_skid_ready_low", s_in_ready, 1'b0);
    check("s_skid_hold_pc",   s_out_pc,   32'h3000);
    s_drive(1'b0, 32'h0, '0, 1'b0);
    tick();
    check("s_skid_stall2", s_stall_cnt, 4'd2);
    s_out_ready = 1'b1;
    tick();
    check("s_skid_b2b_valid", s_out_valid, 1'b1);
    check("s_skid_b2b_pc",    s_out_pc,    32'h3004);
    check("s_skid_ready_hi",  s_in_ready,  1'b1);
    tick();
    check("s_skid_drained", s_out_valid, 1'b0);
    check("s_skid_stall_kept", s_stall_cnt, 4'd2);

    // Full skid, then flush with out_ready=1 and a new entry presented
    s_drive(1'b1, 32'h3010, 64'h110, 1'b0);
    tick();
    s_drive(1'b1, 32'h3014, 64'h114, 1'b0);
    tick();
    check("s_full_stall3", s_stall_cnt, 4'd3);
    s_drive(1'b1, 32'h3018, 64'h118, 1'b1);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    s_drive(1'b0, 32'h0, '0, 1'b1);
    check("s_flush_valid", s_out_valid, 1'b0);
    check("s_flush_ready", s_in_ready,  1'b1);
    check("s_flush_stall", s_stall_cnt, 4'd3);
    tick();
    check("s_flush_gone", s_out_valid, 1'b0);

    // Flush while skid is empty: presented entry would be accepted but is dropped
    s_drive(1'b1, 32'h3020, 64'h120, 1'b0);
    tick();
    s_drive(1'b1, 32'h3024, 64'h124, 1'b0);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    s_drive(1'b0, 32'h0, '0, 1'b1);
    check("s_flush2_valid", s_out_valid, 1'b0);
    check("s_flush2_stall", s_stall_cnt, 4'd4);
    tick();
    check("s_flush2_gone", s_out_valid, 1'b0);

    // Stall counter saturation, then reset clears it
    s_drive(1'b1, 32'h3030, 64'h130, 1'b0);
    tick();
    s_drive(1'b0, 32'h0, '0, 1'b0);
    repeat (16 + 5) tick();
    check("s_sat_cnt", s_stall_cnt, 4'hF);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    check("s_sat_reset_cnt",   s_stall_cnt, 4'h0);
    check("s_sat_reset_valid", s_out_valid, 1'b0);
    s_out_ready = 1'b1;

    // SKID=0: combinational out_ready -> in_ready
    n_drive(1'b1, 32'h3100, 64'h200, 1'b1);
    tick();
    n_drive(1'b0, 32'h0, '0, 1'b0);
    #1;
    check("n_ready_low", n_in_ready, 1'b0);
    n_drive(1'b1, 32'h3104, 64'h204, 1'b1);
    #1;
    check("n_ready_high", n_in_ready, 1'b1);
    tick();
    check("n_replace_pc", n_out_pc, 32'h3104);
    n_drive(1'b0, 32'h0, '0, 1'b1);
    tick();
    check("n_drained", n_out_valid, 1'b0);

    tick(); tick();
    check("s_queue_empty", 128'(s_exp_q.size()), 128'd0);
    check("n_queue_empty", 128'(n_exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
